cla_nibble_sequencer: RTL and testbench
=======================================

# cla_nibble_sequencer

Multi-cycle wide adder controller. It adds two WIDTH-bit operands by driving one shared 4-bit carry-lookahead nibble adder, one nibble per cycle, from LSB to MSB. The carry is registered between nibbles. It sits between a valid/ready operand source and a valid/ready result sink. Wide additions reuse the existing 4-bit CLA datapath rather than instantiating a wide adder.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, minimum 4; NIB = WIDTH/4 nibble passes.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to nibble 0.
- out_valid  output  1  result held and valid.
- out_ready  input  1  sink accepts result.
- sum  output  WIDTH  registered result.
- cout  output  1  carry out of MSB nibble.
- busy  output  1  high in RUN or DONE.
- ovf  output  1  signed overflow; present only with SEQ_OVERFLOW_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a, b, cin into operand registers; clear nibble index idx to 0; load the carry register with cin; go to RUN.
- RUN, each cycle:
  - Nibble adder inputs are a_reg[4*idx+:4], b_reg[4*idx+:4] and carry_reg.
  - Nibble sum is written to sum[4*idx+:4]; carry_reg takes the nibble carry-out; idx increments.
  - When idx==NIB-1, the nibble's carry-out goes to cout, and the FSM goes to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - On out_ready, go to IDLE.
- Inputs in_valid, a, b and cin are ignored outside IDLE. Operands are not re-sampled.
- idx is ceil(log2(NIB)) bits wide, minimum 1. It never exceeds NIB-1; there is no wrap-around.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the true carry of a+b+cin.
- Output values after a completed transaction persist through IDLE until overwritten by the next RUN.

## Timing
- Reset values (asynchronous, applied immediately):
  - state=IDLE, so in_ready=1 and busy=0.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - idx=0, carry_reg=0, operand registers 0.
- Latency: with acceptance at edge T, RUN occupies edges T+1..T+NIB, and out_valid rises after edge T+NIB.
  - Example: WIDTH=16 gives out_valid 4 cycles after acceptance.
- Throughput: one transaction per NIB+2 cycles minimum (accept, NIB passes, handshake). There is no overlap of a new acceptance with DONE.
- out_valid drops the cycle after the out_valid&out_ready edge. in_ready rises in the same cycle.
- Backpressure: DONE holds indefinitely while out_ready=0.
- rst asserted mid-RUN or in DONE aborts the transaction. No result is emitted, and the FSM restarts from IDLE after rst deasserts.
- in_ready, busy and out_valid are decoded from registered state only and have no combinational path from inputs.

## Configuration
- SEQ_OVERFLOW_EN defined:
  - ovf port exists.
  - In the final RUN cycle, ovf is registered as (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), using the nibble adder's internal bit-2 carry.
  - ovf is valid with out_valid and resets to 0.
- SEQ_OVERFLOW_EN undefined: ovf port and its logic are absent. All other behaviour is identical.

## Structure
- Package cla_seq_pkg holds:
  - NIBBLE_W=4.
  - State enum seq_state_t {IDLE, RUN, DONE}.
  - A function for NIB from WIDTH.
- One sub-module, cla_nibble_add: combinational 4-bit carry-lookahead adder.
  - Ports: a4, b4, c_in, s4, c_out, c3.
  - c3 is the carry into bit 3, used for ovf.
  - Instantiated once and shared across all passes.
- All registers and the FSM live in cla_nibble_sequencer.

## Test plan
- WIDTH=16:
  - a=0x1234, b=0x4321, cin=0 -> out_valid 4 cycles after accept, sum=0x5555, cout=0.
  - a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; carry propagates through all nibbles.
  - a=0x0FFF, b=0x0000, cin=1 -> sum=0x1000, cout=0; in_valid toggled with a=0xAAAA during RUN is ignored and in_ready stays 0.
  - out_ready held 0 for 5 cycles in DONE -> sum, cout and out_valid are stable. On out_ready=1, IDLE is entered next cycle and a new accept is possible the following edge.
  - rst pulsed at the second RUN cycle -> out_valid never rises, all outputs 0. A following 0x0001+0x0001 gives 0x0002.
  - With SEQ_OVERFLOW_EN: 0x7FFF+0x0001 -> ovf=1, cout=0; 0xFFFF+0x0001 -> ovf=0, cout=1. WIDTH=4: 0x9+0x8 -> sum=0x1, cout=1, latency 1.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// Shared constants, FSM state type and nibble-count helper for the CLA nibble sequencer.
package cla_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  function automatic int unsigned nib_count(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/cla_nibble_add.sv
// Combinational 4-bit carry-lookahead adder; c3 exposes the carry into bit 3 for overflow.
module cla_nibble_add
  import cla_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] s4,
  output logic                c_out,
  output logic                c3
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] c;

  assign g = a4 & b4;
  assign p = a4 ^ b4;

  // Every carry is a flat sum-of-products of generate/propagate terms.
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);
  assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign s4 = p ^ c;
  assign c3 = c[3];

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Wide adder that reuses one 4-bit CLA, one nibble per cycle, LSB first.
// Optional signed-overflow output enabled by defining SEQ_OVERFLOW_EN.
module cla_nibble_sequencer
  import cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SEQ_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int unsigned NIB   = nib_count(WIDTH);
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  seq_state_t         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
`ifdef SEQ_OVERFLOW_EN
  logic               ovf_q, ovf_d;
`endif

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
  logic                nib_cout, nib_c3;

  // Select the operand nibbles addressed by the current pass.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < int'(NIB); i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
        nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  cla_nibble_add u_add (
    .a4   (nib_a),
    .b4   (nib_b),
    .c_in (carry_q),
    .s4   (nib_s),
    .c_out(nib_cout),
    .c3   (nib_c3)
  );

`ifndef SEQ_OVERFLOW_EN
  logic unused_c3;
  assign unused_c3 = nib_c3;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SEQ_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SEQ_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SEQ_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < int'(NIB); i++) begin
          if (idx_q == IDX_W'(i)) sum_d[i*NIBBLE_W +: NIBBLE_W] = nib_s;
        end
        carry_d = nib_cout;
        if (idx_q == IDX_W'(NIB - 1)) begin
          cout_d  = nib_cout;
`ifdef SEQ_OVERFLOW_EN
          ovf_d   = nib_c3 ^ nib_cout;
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are pure decodes of the state register.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SEQ_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Randomized self-checking bench for cla_nibble_sequencer (WIDTH=16 and WIDTH=4 instances).
module tb_cla_nibble_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [15:0] a, b, sum;
  logic        w4_in_valid, w4_in_ready, w4_cin, w4_out_valid, w4_out_ready;
  logic        w4_cout, w4_busy;
  logic [3:0]  w4_a, w4_b, w4_sum;
`ifdef SEQ_OVERFLOW_EN
  logic        ovf, w4_ovf;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cla_nibble_sequencer #(.WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout),
`ifdef SEQ_OVERFLOW_EN
    .ovf(ovf),
`endif
    .busy(busy)
  );

  cla_nibble_sequencer #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
    .a(w4_a), .b(w4_b), .cin(w4_cin), .out_valid(w4_out_valid),
    .out_ready(w4_out_ready), .sum(w4_sum), .cout(w4_cout),
`ifdef SEQ_OVERFLOW_EN
    .ovf(w4_ovf),
`endif
    .busy(w4_busy)
  );

  // Reference signed overflow: true signed result falls outside the W-bit range.
  function automatic bit ref_ovf(input int w, input int ua, input int ub, input int c);
    int sa, sb, s;
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    s  = sa + sb + c;
    return (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
  endfunction

  task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                         input int hold, input bit toggle, input string name);
    int n;
    int lat;
    bit ready_seen;
    int total;
    logic [15:0] exp_s;
    logic        exp_c;
    logic [15:0] s0;
    logic        c0;
    total = int'(ta) + int'(tb) + int'(tc);
    exp_s = 16'(total % 65536);
    exp_c = (total >= 65536);
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL %s wait_in_ready got %b want 1", name, in_ready);
    end
    in_valid = 1'b1; a = ta; b = tb; cin = tc;
    @(posedge clk); #1;
    if (toggle) begin a = 16'hAAAA; b = 16'h5555; cin = 1'b1; end
    else in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL %s accept in_ready=%b busy=%b want 0/1", name, in_ready, busy);
    end
    lat = 0; ready_seen = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
      if (in_ready === 1'b1) ready_seen = 1;
    end
    in_valid = 1'b0;
    tests++;
    if (lat != 4 || ready_seen) begin
      fails++; $display("FAIL %s latency got %0d want 4 (in_ready_seen=%b)", name, lat, ready_seen);
    end
    tests++;
    if (sum !== exp_s || cout !== exp_c) begin
      fails++; $display("FAIL %s result got %h/%b want %h/%b", name, sum, cout, exp_s, exp_c);
    end
`ifdef SEQ_OVERFLOW_EN
    tests++;
    if (ovf !== ref_ovf(16, int'(ta), int'(tb), int'(tc))) begin
      fails++; $display("FAIL %s ovf got %b want %b", name, ovf, ref_ovf(16, int'(ta), int'(tb), int'(tc)));
    end
`endif
    s0 = sum; c0 = cout;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || sum !== s0 || cout !== c0 || in_ready !== 1'b0) begin
        fails++; $display("FAIL %s hold%0d ov=%b sum=%h cout=%b want 1/%h/%b", name, i, out_valid, sum, cout, s0, c0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || sum !== exp_s) begin
      fails++; $display("FAIL %s release ov=%b ir=%b busy=%b sum=%h want 0/1/0/%h", name, out_valid, in_ready, busy, sum, exp_s);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 0;
    w4_in_valid = 0; w4_a = 0; w4_b = 0; w4_cin = 0; w4_out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0) begin
      fails++; $display("FAIL reset ir=%b busy=%b ov=%b sum=%h cout=%b want 1/0/0/0000/0", in_ready, busy, out_valid, sum, cout);
    end
`ifdef SEQ_OVERFLOW_EN
    tests++;
    if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_txn(16'h1234, 16'h4321, 1'b0, 0, 0, "plain");
    run_txn(16'hFFFF, 16'h0001, 1'b0, 0, 0, "ripple");
    run_txn(16'h0FFF, 16'h0000, 1'b1, 0, 1, "ignore_run");
    run_txn(16'h7FFF, 16'h0001, 1'b0, 0, 0, "pos_ovf");
    run_txn(16'h8000, 16'h8000, 1'b0, 0, 0, "neg_ovf");
  endtask

  task automatic test_backpressure();
    run_txn(16'hBEEF, 16'h1111, 1'b1, 5, 0, "backpressure");
    run_txn(16'h0102, 16'h0304, 1'b0, 0, 0, "back_to_back");
  endtask

  task automatic test_reset_mid_run();
    int seen;
    run_txn(16'h1234, 16'h4321, 1'b0, 0, 0, "pre_abort");
    in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL abort ov=%b sum=%h cout=%b ir=%b busy=%b want 0/0000/0/1/0", out_valid, sum, cout, in_ready, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid === 1'b1) seen++; end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL abort_no_result out_valid cycles got %0d want 0", seen); end
    run_txn(16'h0001, 16'h0001, 1'b0, 0, 0, "after_abort");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_txn(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
              bit'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_width4();
    int lat;
    int total;
    logic [3:0] ta, tb;
    logic tc;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin ta = 4'h9; tb = 4'h8; tc = 1'b0; end
      else begin ta = 4'($urandom); tb = 4'($urandom); tc = 1'($urandom); end
      total = int'(ta) + int'(tb) + int'(tc);
      w4_in_valid = 1'b1; w4_a = ta; w4_b = tb; w4_cin = tc;
      @(posedge clk); #1;
      w4_in_valid = 1'b0;
      lat = 0;
      while (w4_out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      tests++;
      if (lat != 1 || w4_sum !== 4'(total % 16) || w4_cout !== (total >= 16)) begin
        fails++; $display("FAIL w4 lat=%0d sum=%h cout=%b want 1/%h/%b", lat, w4_sum, w4_cout, 4'(total % 16), (total >= 16));
      end
`ifdef SEQ_OVERFLOW_EN
      tests++;
      if (w4_ovf !== ref_ovf(4, int'(ta), int'(tb), int'(tc))) begin
        fails++; $display("FAIL w4_ovf got %b want %b", w4_ovf, ref_ovf(4, int'(ta), int'(tb), int'(tc)));
      end
`endif
      w4_out_ready = 1'b1;
      @(posedge clk); #1;
      w4_out_ready = 1'b0;
      tests++;
      if (w4_out_valid !== 1'b0 || w4_in_ready !== 1'b1) begin
        fails++; $display("FAIL w4_release ov=%b ir=%b want 0/1", w4_out_valid, w4_in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    test_width4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
